// File: rtl/apb_slave_regfile_pkg.sv
// Shared definitions for the APB register-file completer: FSM states,
// pprot bit positions and geometry helpers.
package apb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  localparam int PPROT_PRIV_BIT  = 0;
  localparam int PPROT_NSEC_BIT  = 1;
  localparam int PPROT_INSTR_BIT = 2;

  // Byte-offset bits below the register index.
  function automatic int lsb_of(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int idx_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/apb_slave_regfile_addr_decode.sv
// Combinational address decode: maps a byte address to a register index and
// flags out-of-window, misaligned, read-only and privilege violations.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [DEPTH-1:0]      RO_MASK    = '0,
  parameter bit                    PROT_CHECK = 1'b0,
  localparam int                   IDX_W      = idx_width(DEPTH)
) (
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  pwrite,
  input  logic [2:0]            pprot,
  output logic [IDX_W-1:0]      index,
  output logic                  err
);

  localparam int                    LSB        = lsb_of(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] SPAN       = ADDR_WIDTH'(DEPTH * (DATA_WIDTH / 8));
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((DATA_WIDTH / 8) - 1);

  logic [ADDR_WIDTH-1:0] off_s;
  logic                  below_s;
  logic                  range_s;
  logic                  misalign_s;
  logic                  ro_s;
  logic                  prot_s;
  logic                  unused_s;

  // Offset arithmetic and the individual error causes.
  always_comb begin
    off_s      = paddr - BASE_ADDR;
    below_s    = (paddr < BASE_ADDR);
    range_s    = (off_s >= SPAN);
    misalign_s = |(off_s & ALIGN_MASK);
    index      = off_s[LSB +: IDX_W];
    ro_s       = pwrite & RO_MASK[index];
    prot_s     = PROT_CHECK & pwrite & ~pprot[PPROT_PRIV_BIT];
    err        = below_s | range_s | misalign_s | ro_s | prot_s;
  end

  assign unused_s = ^{pprot, off_s};

endmodule

// File: rtl/apb_slave_regfile.sv
// APB4 completer exposing a DEPTH-entry register file with byte strobes,
// fixed wait states, read-only masking and slave-error responses.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0,
  parameter logic [DEPTH-1:0]      RO_MASK     = '0,
  parameter bit                    PROT_CHECK  = 1'b0
) (
  input  logic                        pclk,
  input  logic                        preset,
  input  logic                        psel,
  input  logic                        penable,
  input  logic                        pwrite,
  input  logic [ADDR_WIDTH-1:0]       paddr,
  input  logic [2:0]                  pprot,
  input  logic [DATA_WIDTH-1:0]       pwdata,
  input  logic [DATA_WIDTH/8-1:0]     pstrb,
  output logic [DATA_WIDTH-1:0]       prdata,
  output logic                        pready,
  output logic                        pslverr,
  output logic [DEPTH*DATA_WIDTH-1:0] regs
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam int NB    = DATA_WIDTH / 8;

  apb_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  err_q, err_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];

  logic [IDX_W-1:0]      dec_idx_s;
  logic                  dec_err_s;
  logic                  complete_s;
  logic                  wr_fire_s;

  function automatic logic [DATA_WIDTH-1:0] strobe_merge(
    input logic [DATA_WIDTH-1:0] old_val,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [NB-1:0]         strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_val;
    for (int b = 0; b < NB; b++) begin
      if (strb[b]) begin
        res[b*8 +: 8] = wdata[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = old_val[b*8 +: 8];
      end
    end
    return res;
  endfunction

  apb_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .BASE_ADDR  (BASE_ADDR),
    .RO_MASK    (RO_MASK),
    .PROT_CHECK (PROT_CHECK)
  ) u_decode (
    .paddr  (paddr),
    .pwrite (pwrite),
    .pprot  (pprot),
    .index  (dec_idx_s),
    .err    (dec_err_s)
  );

  // pready depends only on flops, never on the incoming bus signals.
  assign pready     = (state_q == ST_ACCESS) && (cnt_q == 4'd0);
  assign pslverr    = err_q & pready;
  assign prdata     = prdata_q;
  assign complete_s = psel & penable & pready;
  assign wr_fire_s  = complete_s & wr_q & ~err_q;

  // Transfer sequencing: setup latches decode and read data, access counts down.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    err_d    = err_q;
    wr_d     = wr_q;
    prdata_d = prdata_q;
    case (state_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          state_d = ST_ACCESS;
          cnt_d   = 4'(WAIT_STATES);
          idx_d   = dec_idx_s;
          err_d   = dec_err_s;
          wr_d    = pwrite;
          if (!pwrite && !dec_err_s) begin
            prdata_d = regs_q[dec_idx_s];
          end else begin
            prdata_d = '0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!psel) begin
          state_d = ST_IDLE;
        end else if (penable) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_ACCESS;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Byte-strobed update of the addressed register on a clean write completion.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_fire_s) begin
      regs_d[idx_q] = strobe_merge(regs_q[idx_q], pwdata, pstrb);
    end else begin
      regs_d[idx_q] = regs_q[idx_q];
    end
  end

  // Control and read-data flops.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      wr_q     <= wr_d;
      prdata_q <= prdata_d;
    end
  end

  // Register array storage.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_regs_out
    assign regs[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench: three completer instances (no wait states; three wait
// states; two wait states with read-only reg 2 and privilege checking).
module tb_apb_slave_regfile;

  logic        pclk;
  logic        preset;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;

  logic [31:0]   prdata_w  [3];
  logic          pready_w  [3];
  logic          pslverr_w [3];
  logic [1023:0] regs_w    [3];

  int checks_cnt;
  int fail_cnt;

  logic [31:0] rd;
  logic        err;
  int          ncyc;

  apb_slave_regfile #(.WAIT_STATES(0)) u_dut0 (
    .pclk(pclk), .preset(preset), .psel(psel[0]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pprot(pprot), .pwdata(pwdata),
    .pstrb(pstrb), .prdata(prdata_w[0]), .pready(pready_w[0]),
    .pslverr(pslverr_w[0]), .regs(regs_w[0])
  );

  apb_slave_regfile #(.WAIT_STATES(3)) u_dut1 (
    .pclk(pclk), .preset(preset), .psel(psel[1]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pprot(pprot), .pwdata(pwdata),
    .pstrb(pstrb), .prdata(prdata_w[1]), .pready(pready_w[1]),
    .pslverr(pslverr_w[1]), .regs(regs_w[1])
  );

  apb_slave_regfile #(.WAIT_STATES(2), .RO_MASK(32'h0000_0004), .PROT_CHECK(1'b1)) u_dut2 (
    .pclk(pclk), .preset(preset), .psel(psel[2]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pprot(pprot), .pwdata(pwdata),
    .pstrb(pstrb), .prdata(prdata_w[2]), .pready(pready_w[2]),
    .pslverr(pslverr_w[2]), .regs(regs_w[2])
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Full transfer on instance d; returns read data, error and access-cycle count.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      input logic [2:0] prot, output logic [31:0] rdata,
                      output logic slverr, output int cycles);
    @(negedge pclk);
    psel       = 3'b000;
    psel[d]    = 1'b1;
    penable    = 1'b0;
    pwrite     = wr;
    paddr      = addr;
    pwdata     = data;
    pstrb      = strb;
    pprot      = prot;
    @(negedge pclk);
    penable = 1'b1;
    cycles  = 1;
    while (!pready_w[d] && cycles < 40) begin
      @(negedge pclk);
      cycles++;
    end
    if (!pready_w[d]) begin
      check_val("pready_timeout", 32'(pready_w[d]), 32'd1);
    end
    rdata  = prdata_w[d];
    slverr = pslverr_w[d];
  endtask

  task automatic bus_idle();
    @(negedge pclk);
    psel    = 3'b000;
    penable = 1'b0;
  endtask

  initial begin
    checks_cnt = 0;
    fail_cnt   = 0;
    preset     = 1'b0;
    psel       = 3'b000;
    penable    = 1'b0;
    pwrite     = 1'b0;
    paddr      = 32'h0;
    pprot      = 3'b000;
    pwdata     = 32'h0;
    pstrb      = 4'h0;
    #12;
    check_val("rst_pready",  32'(pready_w[0]),  32'd0);
    check_val("rst_pslverr", 32'(pslverr_w[0]), 32'd0);
    check_val("rst_prdata",  prdata_w[0],       32'h0);
    check_val("rst_regs",    32'(|regs_w[0]),   32'd0);
    @(negedge pclk);
    preset = 1'b1;

    // Strobed writes, zero wait states
    xfer(0, 1'b1, 32'h08, 32'hAABBCCDD, 4'b1111, 3'b000, rd, err, ncyc);
    check_val("wr_full_err", 32'(err), 32'd0);
    check_val("wr_full_cyc", 32'(ncyc), 32'd1);
    xfer(0, 1'b1, 32'h08, 32'h11223344, 4'b0101, 3'b000, rd, err, ncyc);
    xfer(0, 1'b0, 32'h08, 32'h0, 4'b0000, 3'b000, rd, err, ncyc);
    check_val("strb_rd_data", rd, 32'hAA22CC44);
    check_val("strb_rd_cyc",  32'(ncyc), 32'd1);
    check_val("strb_rd_err",  32'(err), 32'd0);
    check_val("strb_regs",    regs_w[0][95:64], 32'hAA22CC44);

    // Error responses and zero-strobe write
    xfer(0, 1'b1, 32'h04, 32'h12345678, 4'b1111, 3'b000, rd, err, ncyc);
    xfer(0, 1'b1, 32'h06, 32'hFFFFFFFF, 4'b1111, 3'b000, rd, err, ncyc);
    check_val("misalign_err", 32'(err), 32'd1);
    xfer(0, 1'b0, 32'h04, 32'h0, 4'b0000, 3'b000, rd, err, ncyc);
    check_val("misalign_keep", rd, 32'h12345678);
    check_val("rd_after_misalign_err", 32'(err), 32'd0);
    xfer(0, 1'b0, 32'h80, 32'h0, 4'b1111, 3'b000, rd, err, ncyc);
    check_val("oor_err",  32'(err), 32'd1);
    check_val("oor_data", rd, 32'h0);
    xfer(0, 1'b1, 32'h04, 32'hDEADBEEF, 4'b0000, 3'b000, rd, err, ncyc);
    check_val("strb0_err", 32'(err), 32'd0);
    xfer(0, 1'b0, 32'h04, 32'h0, 4'b0000, 3'b000, rd, err, ncyc);
    check_val("strb0_keep", rd, 32'h12345678);
    bus_idle();

    // Reset asserted while a read is completing
    @(negedge pclk);
    psel    = 3'b001;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 32'h08;
    @(negedge pclk);
    penable = 1'b1;
    check_val("pre_rst_pready", 32'(pready_w[0]), 32'd1);
    check_val("pre_rst_prdata", prdata_w[0], 32'hAA22CC44);
    #2;
    preset = 1'b0;
    #1;
    check_val("midrst_pready",  32'(pready_w[0]),  32'd0);
    check_val("midrst_pslverr", 32'(pslverr_w[0]), 32'd0);
    check_val("midrst_prdata",  prdata_w[0],       32'h0);
    check_val("midrst_regs",    32'(|regs_w[0]),   32'd0);
    @(negedge pclk);
    psel    = 3'b000;
    penable = 1'b0;
    preset  = 1'b1;
    xfer(0, 1'b0, 32'h04, 32'h0, 4'b0000, 3'b000, rd, err, ncyc);
    check_val("post_rst_rd", rd, 32'h0);
    check_val("post_rst_err", 32'(err), 32'd0);
    bus_idle();

    // Three wait states, back-to-back transfers
    xfer(1, 1'b0, 32'h00, 32'h0, 4'b0000, 3'b000, rd, err, ncyc);
    check_val("ws3_rd0_cyc",  32'(ncyc), 32'd4);
    check_val("ws3_rd0_data", rd, 32'h0);
    xfer(1, 1'b1, 32'h00, 32'hCAFEF00D, 4'b1111, 3'b000, rd, err, ncyc);
    check_val("ws3_wr_cyc", 32'(ncyc), 32'd4);
    xfer(1, 1'b0, 32'h00, 32'h0, 4'b0000, 3'b000, rd, err, ncyc);
    check_val("ws3_b2b_cyc",  32'(ncyc), 32'd4);
    check_val("ws3_b2b_data", rd, 32'hCAFEF00D);
    bus_idle();

    // Read-only register and privilege checking
    xfer(2, 1'b1, 32'h08, 32'h55555555, 4'b1111, 3'b001, rd, err, ncyc);
    check_val("ro_err", 32'(err), 32'd1);
    check_val("ro_cyc", 32'(ncyc), 32'd3);
    xfer(2, 1'b0, 32'h08, 32'h0, 4'b0000, 3'b000, rd, err, ncyc);
    check_val("ro_keep", rd, 32'h0);
    check_val("ro_rd_err", 32'(err), 32'd0);
    xfer(2, 1'b1, 32'h0C, 32'h0BADF00D, 4'b1111, 3'b000, rd, err, ncyc);
    check_val("unpriv_err", 32'(err), 32'd1);
    check_val("unpriv_keep", regs_w[2][127:96], 32'h0);
    xfer(2, 1'b1, 32'h0C, 32'h0BADF00D, 4'b1111, 3'b001, rd, err, ncyc);
    check_val("priv_err", 32'(err), 32'd0);
    xfer(2, 1'b0, 32'h0C, 32'h0, 4'b0000, 3'b000, rd, err, ncyc);
    check_val("priv_data", rd, 32'h0BADF00D);

    // psel dropped mid-write: nothing written, next read still works
    @(negedge pclk);
    psel    = 3'b100;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h10;
    pwdata  = 32'hA5A5A5A5;
    pstrb   = 4'b1111;
    pprot   = 3'b001;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel    = 3'b000;
    penable = 1'b0;
    @(negedge pclk);
    check_val("abort_pready", 32'(pready_w[2]), 32'd0);
    check_val("abort_regs",   regs_w[2][159:128], 32'h0);
    xfer(2, 1'b0, 32'h10, 32'h0, 4'b0000, 3'b000, rd, err, ncyc);
    check_val("abort_rd_data", rd, 32'h0);
    check_val("abort_rd_cyc",  32'(ncyc), 32'd3);
    check_val("abort_rd_err",  32'(err), 32'd0);
    bus_idle();
    @(negedge pclk);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
